// File: rtl/cubic_tap_sequencer.sv
// Fetch/control stage ahead of the 4-tap cubic engine: steps a Q8.8
// position, issues clamped neighbour reads and sequences cycle_cnt.
module cubic_tap_sequencer #(
    parameter int AW = 16,
    parameter int LW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [AW-1:0]   stride,
    input  logic [LW-1:0]   src_len,
    input  logic [LW-1:0]   dst_cnt,
    input  logic [LW+7:0]   start_pos,
    input  logic [LW+7:0]   step,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    input  logic [7:0]      rd_data,
    output logic [2:0]      cycle_cnt,
    output logic [23:0]     X_in,
    output logic [7:0]      P_in,
    output logic            res_valid,
    output logic [LW-1:0]   res_idx,
    output logic            busy,
    output logic            done
);
    localparam int PW = LW + 8;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t          state;
    logic [AW-1:0]   base_r;
    logic [AW-1:0]   stride_r;
    logic [LW-1:0]   len_r;
    logic [LW-1:0]   dst_r;
    logic [PW-1:0]   step_r;
    logic [PW-1:0]   pos;
    logic [LW-1:0]   n;
    logic [LW-1:0]   n_inc;

    logic [PW:0]     pos_sum;
    logic [PW-1:0]   pos_next;
    logic            accept;

    logic [PW-1:0]   a_pos;
    logic signed [2:0] a_k;
    logic [AW-1:0]   a_base;
    logic [AW-1:0]   a_stride;
    logic [LW-1:0]   a_len;
    logic [LW-1:0]   hi;
    logic signed [LW+1:0] t;
    logic [LW-1:0]   idx;
    logic [LW+AW-1:0] prod;
    logic [AW-1:0]   a_addr;
    logic [7:0]      f;
    logic [15:0]     sq;
    logic [15:0]     cu;
    logic [7:0]      f2;
    logic [7:0]      f3;
    logic [23:0]     fx;

    assign P_in     = rd_data;
    assign n_inc    = n + LW'(1);
    assign pos_sum  = {1'b0, pos} + {1'b0, step_r};
    assign pos_next = pos_sum[PW] ? '1 : pos_sum[PW-1:0];
    assign accept   = (state == IDLE) && start;

    // Select the position/tap whose address is registered at this edge
    always_comb begin
        a_pos    = pos;
        a_k      = $signed({1'b0, cycle_cnt[1:0]});
        a_base   = base_r;
        a_stride = stride_r;
        a_len    = len_r;
        if (accept) begin
            a_pos    = start_pos;
            a_k      = -3'sd1;
            a_base   = base_addr;
            a_stride = stride;
            a_len    = src_len;
        end else if (cycle_cnt == 3'd4) begin
            a_pos = pos_next;
            a_k   = -3'sd1;
        end
    end

    always_comb begin
        hi = (a_len == '0) ? '0 : a_len - LW'(1);
        t  = $signed({2'b00, a_pos[PW-1:8]}) + (LW+2)'(a_k);
        if (t < 0)
            idx = '0;
        else if (t > $signed({2'b00, hi}))
            idx = hi;
        else
            idx = t[LW-1:0];
        prod   = {{LW{1'b0}}, a_stride} * {{AW{1'b0}}, idx};
        a_addr = a_base + prod[AW-1:0];
    end

    always_comb begin
        f  = a_pos[7:0];
        sq = {8'b0, f} * {8'b0, f} + 16'd128;
        f2 = sq[15:8];
        cu = {8'b0, f2} * {8'b0, f} + 16'd128;
        f3 = cu[15:8];
        fx = {f3, f2, f};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cycle_cnt <= 3'd5;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            X_in      <= '0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            base_r    <= '0;
            stride_r  <= '0;
            len_r     <= '0;
            dst_r     <= '0;
            step_r    <= '0;
            pos       <= '0;
            n         <= '0;
        end else begin
            done      <= 1'b0;
            res_valid <= 1'b0;
            // Each cycle_cnt=0 after the first retires the previous sample
            if ((state == RUN || state == FLUSH) &&
                cycle_cnt == 3'd0 && n != '0) begin
                res_valid <= 1'b1;
                res_idx   <= n - LW'(1);
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base_r   <= base_addr;
                        stride_r <= stride;
                        len_r    <= src_len;
                        dst_r    <= dst_cnt;
                        step_r   <= step;
                        pos      <= start_pos;
                        n        <= '0;
                        if (dst_cnt == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            cycle_cnt <= 3'd0;
                            rd_en     <= 1'b1;
                            rd_addr   <= a_addr;
                            X_in      <= fx;
                        end
                    end
                end
                RUN: begin
                    if (cycle_cnt == 3'd4) begin
                        pos       <= pos_next;
                        n         <= n_inc;
                        cycle_cnt <= 3'd0;
                        if (n_inc == dst_r) begin
                            state <= FLUSH;
                            rd_en <= 1'b0;
                            X_in  <= '0;
                        end else begin
                            rd_en   <= 1'b1;
                            rd_addr <= a_addr;
                            X_in    <= fx;
                        end
                    end else if (cycle_cnt == 3'd3) begin
                        cycle_cnt <= 3'd4;
                        rd_en     <= 1'b0;
                    end else begin
                        cycle_cnt <= cycle_cnt + 3'd1;
                        rd_en     <= 1'b1;
                        rd_addr   <= a_addr;
                    end
                end
                FLUSH: begin
                    state     <= DONE;
                    cycle_cnt <= 3'd5;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cubic_tap_sequencer.sv
// Randomized bench for cubic_tap_sequencer against a cycle-indexed
// reference model derived from the job parameters.
module tb_cubic_tap_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] stride;
    logic [7:0]  src_len;
    logic [7:0]  dst_cnt;
    logic [15:0] start_pos;
    logic [15:0] step;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic [2:0]  cycle_cnt;
    logic [23:0] X_in;
    logic [7:0]  P_in;
    logic        res_valid;
    logic [7:0]  res_idx;
    logic        busy;
    logic        done;

    logic [7:0] mem [0:65535];

    int checks = 0;
    int errors = 0;
    int j_base, j_stride, j_len, j_dst, j_sp, j_step;
    bit aborted;
    int done_seen;

    always #5 clk = ~clk;

    cubic_tap_sequencer #(.AW(16), .LW(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .base_addr(base_addr), .stride(stride),
        .src_len(src_len), .dst_cnt(dst_cnt),
        .start_pos(start_pos), .step(step),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .cycle_cnt(cycle_cnt), .X_in(X_in), .P_in(P_in),
        .res_valid(res_valid), .res_idx(res_idx),
        .busy(busy), .done(done)
    );

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pos_of(int s);
        longint v = longint'(j_sp) + longint'(s) * longint'(j_step);
        return (v > 65535) ? 65535 : int'(v);
    endfunction

    function automatic int fx(int p);
        int f = p & 255;
        int f2 = (f * f + 128) / 256;
        int f3 = (f2 * f + 128) / 256;
        return (f3 << 16) | (f2 << 8) | f;
    endfunction

    function automatic int taddr(int p, int k);
        int t = (p >> 8) + k;
        int hi = (j_len == 0) ? 0 : j_len - 1;
        if (t < 0) t = 0;
        if (t > hi) t = hi;
        return (j_base + t * j_stride) & 16'hFFFF;
    endfunction

    task automatic check_idle(int want_done);
        check("cc_idle", 32'(cycle_cnt), 5);
        check("busy_idle", 32'(busy), 0);
        check("done_idle", 32'(done), want_done);
        check("rden_idle", 32'(rd_en), 0);
        check("rv_idle", 32'(res_valid), 0);
    endtask

    task automatic check_cycle(int r);
        int last = 5 * j_dst;
        int s, ph, p;
        if (aborted) begin
            check_idle(0);
        end else if (j_dst == 0) begin
            check_idle(r == 1 ? 1 : 0);
        end else if (r <= last) begin
            s = (r - 1) / 5;
            ph = (r - 1) % 5;
            p = pos_of(s);
            check("cc", 32'(cycle_cnt), ph);
            check("busy", 32'(busy), 1);
            check("done", 32'(done), 0);
            check("rden", 32'(rd_en), (ph < 4) ? 1 : 0);
            if (ph < 4) check("addr", 32'(rd_addr), taddr(p, ph - 1));
            if (ph >= 1) check("pin", 32'(P_in), 32'(mem[taddr(p, ph - 2)]));
            check("xin", 32'(X_in), fx(p));
            check("rv", 32'(res_valid), (ph == 1 && s >= 1) ? 1 : 0);
            if (ph == 1 && s >= 1) check("ridx", 32'(res_idx), s - 1);
        end else if (r == last + 1) begin
            check("cc_flush", 32'(cycle_cnt), 0);
            check("busy_flush", 32'(busy), 1);
            check("rden_flush", 32'(rd_en), 0);
            check("xin_flush", 32'(X_in), 0);
            check("rv_flush", 32'(res_valid), 0);
            check("done_flush", 32'(done), 0);
        end else if (r == last + 2) begin
            check("cc_done", 32'(cycle_cnt), 5);
            check("done_done", 32'(done), 1);
            check("busy_done", 32'(busy), 0);
            check("rv_done", 32'(res_valid), 1);
            check("ridx_done", 32'(res_idx), j_dst - 1);
            check("rden_done", 32'(rd_en), 0);
        end else begin
            check_idle(0);
        end
    endtask

    task automatic run_job(int b, int st, int len, int dst, int sp, int stp,
                           int bs, int rst_at, int x0);
        int span = 5 * dst + 5;
        @(negedge clk);
        base_addr = 16'(b); stride = 16'(st); src_len = 8'(len);
        dst_cnt = 8'(dst); start_pos = 16'(sp); step = 16'(stp);
        start = 1'b1;
        j_base = b; j_stride = st; j_len = len; j_dst = dst;
        j_sp = sp; j_step = stp;
        aborted = 1'b0;
        done_seen = 0;
        for (int r = 1; r <= span; r++) begin
            @(negedge clk);
            start = (r == bs);
            if (r == 1 || r == bs) begin
                base_addr = 16'($urandom); stride = 16'($urandom);
                src_len = 8'($urandom); dst_cnt = 8'($urandom);
                start_pos = 16'($urandom); step = 16'($urandom);
            end
            if (rst_at > 0 && r == rst_at + 1) begin
                rst = 1'b0;
                aborted = 1'b1;
                check("rst_rden", 32'(rd_en), 0);
            end
            if (done) done_seen++;
            check_cycle(r);
            if (r == 1 && x0 >= 0) check("x0", 32'(X_in), x0);
            if (rst_at > 0 && r == rst_at) rst = 1'b1;
        end
        check("done_count", done_seen, (rst_at > 0) ? 0 : 1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst = 1'b1; start = 1'b0; rd_data = 8'h0;
        base_addr = '0; stride = '0; src_len = '0; dst_cnt = '0;
        start_pos = '0; step = '0;
        repeat (2) @(negedge clk);
        check("rst_cc", 32'(cycle_cnt), 5);
        check("rst_rden", 32'(rd_en), 0);
        check("rst_addr", 32'(rd_addr), 0);
        check("rst_xin", 32'(X_in), 0);
        check("rst_rv", 32'(res_valid), 0);
        check("rst_ridx", 32'(res_idx), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b0;

        run_job(0, 1, 4, 2, 16'h0080, 16'h0100, 0, 0, 24'h204080);
        run_job(0, 1, 4, 1, 16'h03FF, 16'h0100, 0, 0, 24'hFDFEFF);
        run_job(16'h0100, 128, 8, 1, 16'h0200, 16'h0040, 0, 0, 0);
        run_job(0, 1, 4, 0, 16'h0100, 16'h0100, 0, 0, -1);
        run_job(16'h0020, 3, 10, 3, 16'h0180, 16'h0155, 6, 0, -1);
        run_job(0, 1, 4, 3, 16'h0080, 16'h0100, 0, 4, -1);
        run_job(5, 2, 0, 2, 16'h0280, 16'h0100, 0, 0, -1);
        run_job(16'hFFF0, 16'h1234, 255, 3, 16'hFF80, 16'h0100, 0, 0, -1);

        for (int k = 0; k < 30; k++) begin
            int dst, bs, sp;
            dst = $urandom_range(0, 5);
            bs = (dst > 0 && $urandom_range(0, 1) == 1) ?
                 $urandom_range(1, 5 * dst) : 0;
            sp = ($urandom_range(0, 3) == 0) ? $urandom_range(16'hF000, 16'hFFFF)
                                             : $urandom_range(0, 16'h1FFF);
            run_job($urandom_range(0, 65535), $urandom_range(0, 65535),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                                : $urandom_range(0, 20),
                    dst, sp, $urandom_range(0, 16'h03FF), bs, 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
